// File: rtl/mem_proc_pkg.sv
// Shared types and arithmetic for mem_pair_processor.
//   state_e : controller states LOAD / COMP / DONE
//   mode_e  : pair operator codes (cond, add, sub, abs-diff)
//   combine : applies an operator to one pair and reports overflow and underflow
//             separately. The result wraps; any clamping is left to the caller.
// combine works at MAXW bits. Callers zero-extend their operands, so DWIDTH
// must be below MAXW.
package mem_proc_pkg;

  typedef enum logic [1:0] {
    LOAD = 2'b00,
    COMP = 2'b01,
    DONE = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    MODE_COND = 2'b00,
    MODE_ADD  = 2'b01,
    MODE_SUB  = 2'b10,
    MODE_ABS  = 2'b11
  } mode_e;

  localparam int MAXW = 32;

  typedef struct packed {
    logic            ovf;
    logic            unf;
    logic [MAXW-1:0] res;
  } comb_t;

  // The operands are unsigned and below 2**dw. The extra top bit carries the
  // add overflow and the borrow of the subtraction.
  function automatic comb_t combine(input mode_e m, input logic [MAXW-1:0] a,
                                    input logic [MAXW-1:0] b, input int dw);
    comb_t         r;
    logic [MAXW:0] ax, bx, sum, diff, rdiff, one, mask;
    one   = {{MAXW{1'b0}}, 1'b1};
    mask  = (one << dw) - one;
    ax    = {1'b0, a};
    bx    = {1'b0, b};
    sum   = ax + bx;
    diff  = ax - bx;
    rdiff = bx - ax;
    r     = '{ovf: 1'b0, unf: 1'b0, res: {MAXW{1'b0}}};
    case (m)
      MODE_COND: begin
        if (ax <= bx) begin
          r.res = sum[MAXW-1:0] & mask[MAXW-1:0];
          r.ovf = (sum > mask);
        end else begin
          r.res = diff[MAXW-1:0] & mask[MAXW-1:0];
        end
      end
      MODE_ADD: begin
        r.res = sum[MAXW-1:0] & mask[MAXW-1:0];
        r.ovf = (sum > mask);
      end
      MODE_SUB: begin
        r.res = diff[MAXW-1:0] & mask[MAXW-1:0];
        r.unf = (ax < bx);
      end
      MODE_ABS: begin
        r.res = (ax >= bx) ? diff[MAXW-1:0] : rdiff[MAXW-1:0];
      end
      default: begin
        r.res = {MAXW{1'b0}};
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/pp_sync_ram.sv
// Simple dual-port RAM with a registered read port.
//   clock, Reset (async, active-high), srst_i (sync clear)
//     Reset and srst_i clear only the read register. The array keeps its contents.
//   we_i / waddr_i / wdata_i : write port
//   raddr_i / rdata_o        : rdata_o <= mem[raddr_i] every cycle (1-cycle latency)
module pp_sync_ram
  #(parameter int AW = 3,
    parameter int DW = 8)
  (input  logic          clock,
   input  logic          Reset,
   input  logic          srst_i,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [DW-1:0] rdata_o);

  logic [DW-1:0] mem_q [2**AW];

  // Write port: no reset, so contents survive Reset and Init.
  always_ff @(posedge clock) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Registered read port, cleared by either reset.
  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      rdata_o <= {DW{1'b0}};
    end else if (srst_i) begin
      rdata_o <= {DW{1'b0}};
    end else begin
      rdata_o <= mem_q[raddr_i];
    end
  end

endmodule

// File: rtl/mem_pair_processor.sv
// Loads 2**AWIDTH words into buffer A. It then combines the pairs
// (A[2k], A[2k+1]) with the operator latched at the end of the load and writes
// the results to buffer B. B is read back through rd_addr / rd_data.
// Ports:
//   clock, Reset (async, active-high), Init (synchronous restart)
//   mode           operator, sampled only on the last accepted load word
//   in_valid/in_data/in_ready   load stream (in_ready is high in LOAD)
//   busy (COMP), done (DONE), ovf (sticky over/underflow flag)
//   rd_addr/rd_data             B read port with a registered 1-cycle latency
// Build option: define MEMPROC_SATURATE_EN to clamp results. Overflow clamps to
// all-ones and underflow clamps to 0. Without it, results wrap.
module mem_pair_processor
  import mem_proc_pkg::*;
  #(parameter int AWIDTH = 3,
    parameter int DWIDTH = 8,
    localparam int BAW = (AWIDTH > 1) ? AWIDTH - 1 : 1)
  (input  logic              clock,
   input  logic              Reset,
   input  logic              Init,
   input  logic [1:0]        mode,
   input  logic              in_valid,
   input  logic [DWIDTH-1:0] in_data,
   output logic              in_ready,
   output logic              busy,
   output logic              done,
   input  logic [BAW-1:0]    rd_addr,
   output logic [DWIDTH-1:0] rd_data,
   output logic              ovf);

  localparam int              DEPTH     = 2**AWIDTH;
  localparam logic [AWIDTH:0] CNT_ZERO  = {(AWIDTH+1){1'b0}};
  localparam logic [AWIDTH:0] CNT_ONE   = (AWIDTH+1)'(1);
  localparam logic [AWIDTH:0] LAST_LOAD = (AWIDTH+1)'(DEPTH - 1);
  localparam logic [AWIDTH:0] LAST_COMP = (AWIDTH+1)'(DEPTH);

  state_e              state_q, state_d;
  logic [AWIDTH:0]     cnt_q, cnt_d;      // LOAD: accepted words; COMP: cycle index
  mode_e               mode_q, mode_d;
  logic [DWIDTH-1:0]   a_q, a_d;          // even word of the current pair
  logic                ovf_q, ovf_d;
  logic                a_we_s, b_we_s;
  logic [DWIDTH-1:0]   a_rdata_s, b_wdata_s;
  logic [BAW-1:0]      b_waddr_s;
  comb_t               comb_s;
  logic                unused_s;

  // State and datapath registers. Init is folded into the next-state logic.
  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      state_q <= LOAD;
      cnt_q   <= CNT_ZERO;
      mode_q  <= MODE_COND;
      a_q     <= {DWIDTH{1'b0}};
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      a_q     <= a_d;
      ovf_q   <= ovf_d;
    end
  end

  // The A read issued in COMP cycle c returns during cycle c+1. An odd c
  // therefore sees A[c-1], the even word of a pair. An even c >= 2 sees the
  // odd word, which completes pair (c-2)/2.
  assign comb_s    = combine(mode_q, MAXW'(a_q), MAXW'(a_rdata_s), DWIDTH);
  assign b_waddr_s = BAW'(cnt_q[AWIDTH:1] - AWIDTH'(1));
  assign unused_s  = ^comb_s.res[MAXW-1:DWIDTH];

`ifdef MEMPROC_SATURATE_EN
  // Clamp the written result on overflow or underflow.
  always_comb begin
    if (comb_s.ovf) begin
      b_wdata_s = {DWIDTH{1'b1}};
    end else if (comb_s.unf) begin
      b_wdata_s = {DWIDTH{1'b0}};
    end else begin
      b_wdata_s = comb_s.res[DWIDTH-1:0];
    end
  end
`else
  // Write the result modulo 2**DWIDTH.
  always_comb begin
    b_wdata_s = comb_s.res[DWIDTH-1:0];
  end
`endif

  // Next-state logic and buffer write strobes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    a_d     = a_q;
    ovf_d   = ovf_q;
    a_we_s  = 1'b0;
    b_we_s  = 1'b0;
    if (Init) begin
      state_d = LOAD;
      cnt_d   = CNT_ZERO;
      mode_d  = MODE_COND;
      a_d     = {DWIDTH{1'b0}};
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        LOAD: begin
          if (in_valid) begin
            a_we_s = 1'b1;
            if (cnt_q == LAST_LOAD) begin
              state_d = COMP;
              cnt_d   = CNT_ZERO;
              mode_d  = mode_e'(mode);
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end else begin
            a_we_s = 1'b0;
          end
        end
        COMP: begin
          if (cnt_q == LAST_COMP) begin
            state_d = DONE;
            cnt_d   = CNT_ZERO;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
          if (cnt_q[0]) begin
            a_d = a_rdata_s;
          end else if (cnt_q != CNT_ZERO) begin
            b_we_s = 1'b1;
            ovf_d  = ovf_q | comb_s.ovf | comb_s.unf;
          end else begin
            b_we_s = 1'b0;
          end
        end
        DONE: begin
          state_d = DONE;
        end
        default: begin
          state_d = LOAD;
          cnt_d   = CNT_ZERO;
        end
      endcase
    end
  end

  assign in_ready = (state_q == LOAD);
  assign busy     = (state_q == COMP);
  assign done     = (state_q == DONE);
  assign ovf      = ovf_q;

  // Buffer A: one address serves load writes and compute reads.
  pp_sync_ram #(.AW(AWIDTH), .DW(DWIDTH)) u_ram_a (
    .clock   (clock),
    .Reset   (Reset),
    .srst_i  (Init),
    .we_i    (a_we_s),
    .waddr_i (cnt_q[AWIDTH-1:0]),
    .wdata_i (in_data),
    .raddr_i (cnt_q[AWIDTH-1:0]),
    .rdata_o (a_rdata_s)
  );

  // Buffer B: the controller writes results and rd_addr reads them.
  pp_sync_ram #(.AW(BAW), .DW(DWIDTH)) u_ram_b (
    .clock   (clock),
    .Reset   (Reset),
    .srst_i  (Init),
    .we_i    (b_we_s),
    .waddr_i (b_waddr_s),
    .wdata_i (b_wdata_s),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

endmodule
